app_wr_burst_ctrl: RTL

- Per-channel write burst engine sitting directly downstream of app_arbit, between a channel's write-data FIFO and the DDR3 native app interface.
- When the FIFO holds a full burst, it raises a request to the arbiter and waits for the grant (vaild).
- On grant it pulses start, streams BURST_LEN write commands and data beats into the native interface, then pulses end to release the arbiter.
- Addresses advance linearly across bursts and wrap within a fixed region.

---
 rtl/app_pkg.sv | 20 ++
 rtl/app_wr_burst_ctrl_if.sv | 27 ++
 rtl/app_addr_gen.sv | 44 ++++
 rtl/app_wr_burst_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/app_pkg.sv
// Shared definitions for the DDR3 native-interface burst engines (write and read).
package app_pkg;

   localparam int CMD_W = 3;
   localparam logic [CMD_W-1:0] CMD_WR = 3'b000;
   localparam logic [CMD_W-1:0] CMD_RD = 3'b001;

   // One BL8 command covers eight address units
   localparam int ADDR_STEP_BL8 = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAIT_GNT = 3'd2,
      ST_START    = 3'd3,
      ST_BURST    = 3'd4,
      ST_END      = 3'd5
   } burst_state_e;

endpackage

// File: rtl/app_wr_burst_ctrl_if.sv
// Write side of the DDR3 native app interface: command channel plus write-data channel.
interface app_wr_burst_ctrl_if
   import app_pkg::*;
#(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic                  app_en;
   logic [CMD_W-1:0]      app_cmd;
   logic [ADDR_W-1:0]     app_addr;
   logic                  app_rdy;
   logic                  app_wdf_wren;
   logic                  app_wdf_end;
   logic [DATA_W-1:0]     app_wdf_data;
   logic [DATA_W/8-1:0]   app_wdf_mask;
   logic                  app_wdf_rdy;

   modport master (
      output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
      input  app_rdy, app_wdf_rdy
   );

   modport slave (
      input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
      output app_rdy, app_wdf_rdy
   );
endinterface

// File: rtl/app_addr_gen.sv
// Linear command-address generator that wraps inside a fixed channel region.
module app_addr_gen
   import app_pkg::*;
#(
   parameter int ADDR_W    = 28,
   parameter int ADDR_BASE = 0,
   parameter int ADDR_SPAN = 1 << 20,
   parameter int ADDR_STEP = ADDR_STEP_BL8
) (
   input  logic              I_clk,
   input  logic              I_Rst,
   input  logic              I_step,
   output logic [ADDR_W-1:0] O_addr
);
   localparam logic [ADDR_W:0] BASE_C = (ADDR_W+1)'(ADDR_BASE);
   localparam logic [ADDR_W:0] STEP_C = (ADDR_W+1)'(ADDR_STEP);
   localparam logic [ADDR_W:0] END_C  = (ADDR_W+1)'(ADDR_BASE + ADDR_SPAN);

   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   sum_s;

   // One extra bit so the region end compares cleanly at the top of the address space
   always_comb begin
      sum_s = {1'b0, addr_r} + STEP_C;
   end

   // Address advances only on an accepted command and survives across bursts
   always_ff @(posedge I_clk or posedge I_Rst) begin
      if (I_Rst) begin
         addr_r <= BASE_C[ADDR_W-1:0];
      end else if (I_step) begin
         if (sum_s == END_C) begin
            addr_r <= BASE_C[ADDR_W-1:0];
         end else begin
            addr_r <= sum_s[ADDR_W-1:0];
         end
      end else begin
         addr_r <= addr_r;
      end
   end

   assign O_addr = addr_r;

endmodule

// File: rtl/app_wr_burst_ctrl.sv
// Per-channel DDR3 write burst engine: requests the arbiter once a full burst is
// buffered, then streams BURST_LEN data beats and write commands into the app interface.
module app_wr_burst_ctrl
   import app_pkg::*;
#(
   parameter int ADDR_W    = 28,
   parameter int DATA_W    = 128,
   parameter int CNT_W     = 10,
   parameter int BURST_LEN = 64,
   parameter int ADDR_BASE = 0,
   parameter int ADDR_SPAN = 1 << 20,
   parameter int ADDR_STEP = ADDR_STEP_BL8
) (
   input  logic              I_clk,
   input  logic              I_Rst,
   input  logic              I_calib_done,
   input  logic [CNT_W-1:0]  I_fifo_cnt,
   input  logic [DATA_W-1:0] I_fifo_dout,
   output logic              O_fifo_rd_en,
   output logic              O_req,
   input  logic              I_vaild,
   output logic              O_start,
   output logic              O_end,
   app_wr_burst_ctrl_if.master app
);
   localparam logic [CNT_W-1:0] BL_C   = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

   burst_state_e      state_r;
   logic [CNT_W-1:0]  dcnt_r;
   logic [CNT_W-1:0]  ccnt_r;
   logic              req_r;
   logic              start_r;
   logic              end_r;
   logic              en_r;
   logic              wren_r;
   logic              wdf_hs_s;
   logic              cmd_hs_s;
   logic [CNT_W-1:0]  dcnt_nx_s;
   logic [CNT_W-1:0]  ccnt_nx_s;
   logic [ADDR_W-1:0] addr_s;

   assign wdf_hs_s = wren_r & app.app_wdf_rdy;
   assign cmd_hs_s = en_r & app.app_rdy;

   // Counts after this cycle's handshakes; the valids for next cycle are derived from them
   always_comb begin
      dcnt_nx_s = dcnt_r;
      ccnt_nx_s = ccnt_r;
      if (wdf_hs_s) begin
         dcnt_nx_s = dcnt_r + ONE_C;
      end else begin
         dcnt_nx_s = dcnt_r;
      end
      if (cmd_hs_s) begin
         ccnt_nx_s = ccnt_r + ONE_C;
      end else begin
         ccnt_nx_s = ccnt_r;
      end
   end

   // Burst FSM with registered pulse and valid outputs
   always_ff @(posedge I_clk or posedge I_Rst) begin
      if (I_Rst) begin
         state_r <= ST_IDLE;
         dcnt_r  <= ZERO_C;
         ccnt_r  <= ZERO_C;
         req_r   <= 1'b0;
         start_r <= 1'b0;
         end_r   <= 1'b0;
         en_r    <= 1'b0;
         wren_r  <= 1'b0;
      end else begin
         req_r   <= 1'b0;
         start_r <= 1'b0;
         end_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Waiting for a dropped grant keeps us from re-requesting the burst just finished
               if (I_calib_done && (I_fifo_cnt >= BL_C) && !I_vaild) begin
                  state_r <= ST_REQ;
                  req_r   <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               state_r <= ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
               if (I_vaild) begin
                  state_r <= ST_START;
                  start_r <= 1'b1;
               end else begin
                  state_r <= ST_WAIT_GNT;
               end
            end
            ST_START: begin
               state_r <= ST_BURST;
               dcnt_r  <= ZERO_C;
               ccnt_r  <= ZERO_C;
               wren_r  <= 1'b1;
               en_r    <= 1'b0;
            end
            ST_BURST: begin
               dcnt_r <= dcnt_nx_s;
               ccnt_r <= ccnt_nx_s;
               if (ccnt_nx_s == BL_C) begin
                  state_r <= ST_END;
                  end_r   <= 1'b1;
                  wren_r  <= 1'b0;
                  en_r    <= 1'b0;
               end else begin
                  state_r <= ST_BURST;
                  wren_r  <= (dcnt_nx_s < BL_C);
                  en_r    <= (ccnt_nx_s < dcnt_nx_s);
               end
            end
            ST_END: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               wren_r  <= 1'b0;
               en_r    <= 1'b0;
            end
         endcase
      end
   end

   app_addr_gen #(
      .ADDR_W    (ADDR_W),
      .ADDR_BASE (ADDR_BASE),
      .ADDR_SPAN (ADDR_SPAN),
      .ADDR_STEP (ADDR_STEP)
   ) u_addr_gen (
      .I_clk  (I_clk),
      .I_Rst  (I_Rst),
      .I_step (cmd_hs_s),
      .O_addr (addr_s)
   );

   // FWFT FIFO: the head word is the beat on offer, popped exactly when it is accepted
   assign O_fifo_rd_en     = wdf_hs_s;
   assign O_req            = req_r;
   assign O_start          = start_r;
   assign O_end            = end_r;
   assign app.app_en       = en_r;
   assign app.app_cmd      = CMD_WR;
   assign app.app_addr     = addr_s;
   assign app.app_wdf_wren = wren_r;
   assign app.app_wdf_end  = wren_r;
   assign app.app_wdf_data = I_fifo_dout;
   assign app.app_wdf_mask = {(DATA_W/8){1'b0}};

endmodule
